// File: rtl/pic_core_pkg.sv
// rtl/pic_core_pkg.sv - shared defaults, NOP encoding and stack op codes for the PIC-style core
// Purpose : constants shared by pc_stack_fetch and hw_return_stack.
// Contents: PC_W_DEF, INSTR_W_DEF, STACK_DEPTH_DEF, NOP_WORD, stk_op_e.
package pic_core_pkg;

    localparam int PC_W_DEF        = 11;
    localparam int INSTR_W_DEF     = 14;
    localparam int STACK_DEPTH_DEF = 8;

    // Instruction register contents used when the pipeline is flushed.
    localparam logic [INSTR_W_DEF-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        STK_NONE = 2'd0,
        STK_PUSH = 2'd1,
        STK_POP  = 2'd2
    } stk_op_e;

endpackage

// File: rtl/hw_return_stack.sv
// rtl/hw_return_stack.sv - circular hardware return-address stack
// Purpose : return stack with wrapping pointer; the entry below the pointer is
//           presented combinationally so a pop can steer next_pc in the same cycle.
// Ports   : clk, rst_n (async, active-low), en (update enable), op (stk_op_e code),
//           wdata (address to push), top (entry a pop would return).
//           With PC_STACK_FETCH_STKERR_EN: stk_ovf, stk_unf sticky error flags.
module hw_return_stack
    import pic_core_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [1:0]      op,
    input  logic [PC_W-1:0] wdata,
    output logic [PC_W-1:0] top
`ifdef PC_STACK_FETCH_STKERR_EN
    ,
    output logic            stk_ovf,
    output logic            stk_unf
`endif
);

    localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_dec;
    logic [PC_W-1:0] mem [STACK_DEPTH];

    // Pointer wraps naturally because STACK_DEPTH is a power of two.
    assign sp_dec = sp - SP_W'(1);
    assign top    = mem[sp_dec];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            if (op == STK_POP) begin
                sp <= sp_dec;
            end else if (op == STK_PUSH) begin
                mem[sp] <= wdata;
                sp      <= sp + SP_W'(1);
            end
        end
    end

`ifdef PC_STACK_FETCH_STKERR_EN
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    // Occupancy saturates at both ends; the pointer itself keeps wrapping.
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (en) begin
            if (op == STK_POP) begin
                if (cnt == '0) begin
                    stk_unf <= 1'b1;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end else if (op == STK_PUSH) begin
                if (cnt == CNT_W'(STACK_DEPTH)) begin
                    stk_ovf <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/pc_stack_fetch.sv
// rtl/pc_stack_fetch.sv - program counter, instruction register and return-stack fetch unit
// Purpose : drives the ROM address from the PC, registers the returned word into IR
//           (one-cycle fetch latency), and handles jump/call/return/skip flushes.
// Ports   : clk, rst_n (async, active-low), Rom_addr_out, Rom_data_in, stall, jump,
//           jmp_addr, push, pop, skip, ir_out, ir_valid.
// Option  : define PC_STACK_FETCH_STKERR_EN to add stk_ovf / stk_unf outputs.
module pc_stack_fetch
    import pic_core_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    Rom_addr_out,
    input  logic [INSTR_W-1:0] Rom_data_in,
    input  logic               stall,
    input  logic               jump,
    input  logic [PC_W-1:0]    jmp_addr,
    input  logic               push,
    input  logic               pop,
    input  logic               skip,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid
`ifdef PC_STACK_FETCH_STKERR_EN
    ,
    output logic               stk_ovf,
    output logic               stk_unf
`endif
);

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    next_pc;
    logic [PC_W-1:0]    stack_top;
    logic [INSTR_W-1:0] ir;
    logic               valid;
    logic               flush;
    logic [1:0]         stk_op;

    // Pop wins over push so a simultaneous request behaves as a plain return.
    assign stk_op = pop  ? STK_POP :
                    push ? STK_PUSH : STK_NONE;

    assign flush   = jump | pop | skip;
    assign next_pc = pop  ? stack_top :
                     jump ? jmp_addr  : pc + PC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            ir    <= INSTR_W'(NOP_WORD);
            valid <= 1'b0;
        end else if (!stall) begin
            pc    <= next_pc;
            ir    <= flush ? INSTR_W'(NOP_WORD) : Rom_data_in;
            valid <= ~flush;
        end
    end

    // The stack stores the current PC, which already points past the CALL.
    hw_return_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall),
        .op    (stk_op),
        .wdata (pc),
        .top   (stack_top)
`ifdef PC_STACK_FETCH_STKERR_EN
        ,
        .stk_ovf (stk_ovf),
        .stk_unf (stk_unf)
`endif
    );

    assign Rom_addr_out = pc;
    assign ir_out       = ir;
    assign ir_valid     = valid;

endmodule

// File: tb/tb_pc_stack_fetch.sv
// tb/tb_pc_stack_fetch.sv - scoreboard bench for pc_stack_fetch with directed vectors
module tb_pc_stack_fetch;

    logic        clk;
    logic        rst_n;
    logic [10:0] rom_addr;
    logic [13:0] rom_data;
    logic        stall;
    logic        jump;
    logic [10:0] jmp_addr;
    logic        push;
    logic        pop;
    logic        skip;
    logic [13:0] ir_out;
    logic        ir_valid;
`ifdef PC_STACK_FETCH_STKERR_EN
    logic        stk_ovf;
    logic        stk_unf;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [10:0] pc;
        logic [13:0] ir;
        logic        valid;
        string       name;
    } exp_t;

    exp_t sb[$];

    // ROM word = 3'b101 followed by its address, i.e. 0x2800 | addr.
    assign rom_data = {3'b101, rom_addr};

    pc_stack_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Rom_addr_out (rom_addr),
        .Rom_data_in  (rom_data),
        .stall        (stall),
        .jump         (jump),
        .jmp_addr     (jmp_addr),
        .push         (push),
        .pop          (pop),
        .skip         (skip),
        .ir_out       (ir_out),
        .ir_valid     (ir_valid)
`ifdef PC_STACK_FETCH_STKERR_EN
        ,
        .stk_ovf      (stk_ovf),
        .stk_unf      (stk_unf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one set of controls, let one edge consume them, queue the expected state.
    task automatic step(input logic st, input logic jp, input logic [10:0] ja,
                        input logic ps, input logic pp, input logic sk,
                        input logic [10:0] epc, input logic [13:0] eir,
                        input logic ev, input string name);
        stall    = st;
        jump     = jp;
        jmp_addr = ja;
        push     = ps;
        pop      = pp;
        skip     = sk;
        @(posedge clk);
        #1;
        sb.push_back('{epc, eir, ev, name});
    endtask

    // Monitor: compares every queued expectation against the DUT at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".pc"},    32'(rom_addr), 32'(e.pc));
                chk({e.name, ".ir"},    32'(ir_out),   32'(e.ir));
                chk({e.name, ".valid"}, 32'(ir_valid), 32'(e.valid));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 0; jump = 0; jmp_addr = '0; push = 0; pop = 0; skip = 0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{11'h000, 14'h0000, 1'b0, "reset"});
        rst_n = 1'b1;

        // Free-running fetch out of reset
        step(0,0,11'h000,0,0,0, 11'h001, 14'h2800, 1, "seq1");
        step(0,0,11'h000,0,0,0, 11'h002, 14'h2801, 1, "seq2");
        step(0,0,11'h000,0,0,0, 11'h003, 14'h2802, 1, "seq3");

        // GOTO flushes IR
        step(0,1,11'h00B,0,0,0, 11'h00B, 14'h0000, 0, "jmp_0b");
        step(0,1,11'h019,0,0,0, 11'h019, 14'h0000, 0, "jmp_19");
        step(0,0,11'h000,0,0,0, 11'h01A, 14'h2819, 1, "after_jmp");

        // CALL / RETURN
        step(0,1,11'h00F,0,0,0, 11'h00F, 14'h0000, 0, "jmp_0f");
        step(0,1,11'h015,1,0,0, 11'h015, 14'h0000, 0, "call");
        step(0,0,11'h000,0,0,0, 11'h016, 14'h2815, 1, "in_sub");
        step(0,0,11'h000,0,1,0, 11'h00F, 14'h0000, 0, "ret");
        step(0,0,11'h000,0,0,0, 11'h010, 14'h280F, 1, "after_ret");

        // Stall ignores jump; skip flushes
        step(1,1,11'h123,0,0,0, 11'h010, 14'h280F, 1, "stall1");
        step(1,1,11'h123,0,0,0, 11'h010, 14'h280F, 1, "stall2");
        step(0,0,11'h000,0,0,1, 11'h011, 14'h0000, 0, "skip");
        step(0,0,11'h000,0,0,0, 11'h012, 14'h2811, 1, "after_skip");

        // push+pop acts as pop only, then an underflow reads reset-cleared slot 7
        step(0,1,11'h050,1,0,0, 11'h050, 14'h0000, 0, "call2");
        step(0,0,11'h000,1,1,0, 11'h012, 14'h0000, 0, "pushpop");
        step(0,0,11'h000,0,1,0, 11'h000, 14'h0000, 0, "underflow");
`ifdef PC_STACK_FETCH_STKERR_EN
        chk("stk_unf", 32'(stk_unf), 32'd1);
        chk("stk_ovf_pre", 32'(stk_ovf), 32'd0);
`endif

        // PC wrap
        step(0,1,11'h7FF,0,0,0, 11'h7FF, 14'h0000, 0, "jmp_7ff");
        step(0,0,11'h000,0,0,0, 11'h000, 14'h2FFF, 1, "wrap");

        // Nine pushes of 0x100..0x108, then eight pops return 0x108..0x101
        step(0,1,11'h100,0,0,0, 11'h100, 14'h0000, 0, "jmp_100");
        for (int k = 0; k < 9; k++) begin
            step(0,0,11'h000,1,0,0, 11'(32'h101 + k), 14'(32'h2900 + k), 1, $sformatf("push%0d", k));
`ifdef PC_STACK_FETCH_STKERR_EN
            if (k == 7) chk("stk_ovf_8", 32'(stk_ovf), 32'd0);
            if (k == 8) chk("stk_ovf_9", 32'(stk_ovf), 32'd1);
`endif
        end
        for (int k = 0; k < 8; k++) begin
            step(0,0,11'h000,0,1,0, 11'(32'h108 - k), 14'h0000, 0, $sformatf("pop%0d", k));
        end

        // Reset in the middle of a jump aborts it; fetch restarts at 0
        stall = 0; jump = 1; jmp_addr = 11'h222; push = 1; pop = 0; skip = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sb.push_back('{11'h000, 14'h0000, 1'b0, "mid_reset"});
        @(posedge clk);
        #1;
        jump = 0; push = 0;
        rst_n = 1'b1;
        step(0,0,11'h000,0,0,0, 11'h001, 14'h2800, 1, "post_reset");
        step(0,0,11'h000,0,0,0, 11'h002, 14'h2801, 1, "post_reset2");

        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
